// File: rtl/encoder_ctrl_pkg.sv
// Shared definitions for the rotary-encoder controller: quadrature FSM
// state encodings, AB input codes, step direction codes and a helper that
// maps each FSM state to the AB code it expects to be sitting on.
package encoder_ctrl_pkg;

  // Quadrature FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_WAIT = 3'd7
  } quad_state_e;

  // AB = {a_in, b_in}; detent rest position is 11
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;

  // Detent-completion direction reported by the FSM
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  // AB code a state is resting on; the WAIT state is parked on 11 so that
  // the "both bits changed" test is never applied to it.
  function automatic logic [1:0] state_code(input quad_state_e s);
    logic [1:0] code;
    case (s)
      ST_CW1, ST_CCW3: code = AB_01;
      ST_CW2, ST_CCW2: code = AB_00;
      ST_CW3, ST_CCW1: code = AB_10;
      default:         code = AB_11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/encoder_ctrl_quad_fsm.sv
// Full-detent quadrature sequencer. Follows the CW (11-01-00-10-11) or
// CCW (11-10-00-01-11) Gray sequence, steps back on a reversal, parks in
// WAIT on an illegal double-bit change, and reports a completed detent on
// dir for exactly the cycle in which the closing 11 is sampled.
module quad_fsm
  import encoder_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic a_in,
  input  logic b_in,
  output dir_e dir
);

  quad_state_e state_q, state_d;
  logic [1:0]  ab;
  logic [1:0]  cur_code;

  assign ab       = {a_in, b_in};
  assign cur_code = state_code(state_q);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and detent-completion decode
  always_comb begin
    state_d = state_q;
    dir     = DIR_NONE;
    if (state_q == ST_WAIT) begin
      if (ab == AB_11) state_d = ST_IDLE;
    end else if (ab == ~cur_code) begin
      state_d = ST_WAIT;
    end else if (ab != cur_code) begin
      // Only single-bit changes reach here: each is either the next or the
      // previous code of the current path.
      case (state_q)
        ST_IDLE: state_d = (ab == AB_01) ? ST_CW1 : ST_CCW1;
        ST_CW1:  state_d = (ab == AB_00) ? ST_CW2 : ST_IDLE;
        ST_CW2:  state_d = (ab == AB_10) ? ST_CW3 : ST_CW1;
        ST_CW3: begin
          if (ab == AB_11) begin
            state_d = ST_IDLE;
            dir     = DIR_CW;
          end else begin
            state_d = ST_CW2;
          end
        end
        ST_CCW1: state_d = (ab == AB_00) ? ST_CCW2 : ST_IDLE;
        ST_CCW2: state_d = (ab == AB_01) ? ST_CCW3 : ST_CCW1;
        ST_CCW3: begin
          if (ab == AB_11) begin
            state_d = ST_IDLE;
            dir     = DIR_CCW;
          end else begin
            state_d = ST_CCW2;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/encoder_ctrl.sv
// Rotary-encoder controller: turns detents from quad_fsm into registered
// CW/CCW step pulses and a saturating signed position, and classifies the
// push switch into click / long press (long press recentres the position).
// Optional feature macro ENC_ACCEL_EN: steps arriving within ACCEL_CYC
// cycles of the previous one move the position by ACCEL_STEP instead of 1.
module encoder_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int POS_W    = 8,
  parameter int POS_MIN  = -100,
  parameter int POS_MAX  = 100,
  parameter int POS_INIT = 0,
  parameter int LONG_CYC = 13_500_000
`ifdef ENC_ACCEL_EN
  ,
  parameter int ACCEL_CYC  = 1_350_000,
  parameter int ACCEL_STEP = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    btn_in,
  output logic signed [POS_W-1:0] pos,
  output logic                    step_cw,
  output logic                    step_ccw,
  output logic                    btn_click,
  output logic                    btn_long
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(LONG_CYC - 1);

  localparam logic signed [POS_W:0]   MIN_X  = (POS_W + 1)'(POS_MIN);
  localparam logic signed [POS_W:0]   MAX_X  = (POS_W + 1)'(POS_MAX);
  localparam logic signed [POS_W-1:0] INIT_V = POS_W'(POS_INIT);
  localparam logic signed [POS_W:0]   AMT_ONE = (POS_W + 1)'(1);

  dir_e                    dir;
  logic signed [POS_W-1:0] pos_q, pos_d, pos_step;
  logic signed [POS_W:0]   pos_ext, pos_sum, step_amt;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    step_cw_q, step_ccw_q, click_q, long_q;
  logic                    click_d, long_d;

  quad_fsm u_quad_fsm (
    .clk  (clk),
    .rstn (rstn),
    .a_in (a_in),
    .b_in (b_in),
    .dir  (dir)
  );

`ifdef ENC_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_CYC + 1);
  localparam logic [GAP_W-1:0]      GAP_SAT  = GAP_W'(ACCEL_CYC);
  localparam logic signed [POS_W:0] AMT_FAST = (POS_W + 1)'(ACCEL_STEP);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Cycles since the last step; restarts on every step, saturates
  always_comb begin
    gap_d = gap_q;
    if (dir != DIR_NONE)    gap_d = '0;
    else if (gap_q != GAP_SAT) gap_d = gap_q + 1'b1;
  end

  // Starts saturated so the first step after reset is never accelerated
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) gap_q <= GAP_SAT;
    else       gap_q <= gap_d;
  end

  assign step_amt = (gap_q < GAP_SAT) ? AMT_FAST : AMT_ONE;
`else
  assign step_amt = AMT_ONE;
`endif

  // Position update: widen by one bit, add/subtract, then saturate
  always_comb begin
    pos_ext = $signed({pos_q[POS_W-1], pos_q});
    pos_sum = pos_ext;
    if (dir == DIR_CW)       pos_sum = pos_ext + step_amt;
    else if (dir == DIR_CCW) pos_sum = pos_ext - step_amt;

    if (pos_sum > MAX_X)      pos_step = MAX_X[POS_W-1:0];
    else if (pos_sum < MIN_X) pos_step = MIN_X[POS_W-1:0];
    else                      pos_step = pos_sum[POS_W-1:0];

    // Long press fires on the edge the counter reaches LONG_CYC; it
    // overrides any step landing on the same edge.
    long_d = btn_in && (cnt_q == CNT_PRE);
    pos_d  = long_d ? INIT_V : pos_step;
  end

  // Press counter and click classification
  always_comb begin
    cnt_d   = '0;
    click_d = 1'b0;
    if (btn_in) begin
      cnt_d = (cnt_q == CNT_LONG) ? cnt_q : cnt_q + 1'b1;
    end else begin
      click_d = (cnt_q != '0) && (cnt_q != CNT_LONG);
    end
  end

  // Output and state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_q      <= INIT_V;
      cnt_q      <= '0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      step_cw_q  <= (dir == DIR_CW);
      step_ccw_q <= (dir == DIR_CCW);
      click_q    <= click_d;
      long_q     <= long_d;
    end
  end

  assign pos       = pos_q;
  assign step_cw   = step_cw_q;
  assign step_ccw  = step_ccw_q;
  assign btn_click = click_q;
  assign btn_long  = long_q;

endmodule

// File: tb/tb_encoder_ctrl.sv
// Self-checking bench for encoder_ctrl: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model that
// tracks detent progress as a signed phase count around the Gray cycle.
module tb_encoder_ctrl;

  localparam int LONG     = 1000;
  localparam int ACC_CYC  = 50;
  localparam int ACC_STEP = 4;
  localparam int PMIN     = -100;
  localparam int PMAX     = 100;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              a_in = 1'b1;
  logic              b_in = 1'b1;
  logic              btn_in = 1'b0;
  logic signed [7:0] pos;
  logic              step_cw, step_ccw, btn_click, btn_long;

  always #5 clk = ~clk;

  encoder_ctrl #(
    .POS_W    (8),
    .POS_MIN  (PMIN),
    .POS_MAX  (PMAX),
    .POS_INIT (0),
    .LONG_CYC (LONG)
`ifdef ENC_ACCEL_EN
    ,
    .ACCEL_CYC  (ACC_CYC),
    .ACCEL_STEP (ACC_STEP)
`endif
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a_in      (a_in),
    .b_in      (b_in),
    .btn_in    (btn_in),
    .pos       (pos),
    .step_cw   (step_cw),
    .step_ccw  (step_ccw),
    .btn_click (btn_click),
    .btn_long  (btn_long)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int m_p, m_press, m_pos, m_cyc, m_last;
  bit m_wait, m_have_last;
  bit e_cw, e_ccw, e_click, e_long;

  // Observed pulse tallies for directed checks
  int n_cw, n_ccw, n_click, n_long;

  function automatic int code_idx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] idx_code(input int i);
    case (i)
      0:       return 2'b11;
      1:       return 2'b01;
      2:       return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_wait = 0; m_press = 0; m_pos = 0; m_cyc = 0;
    m_last = 0; m_have_last = 0;
    e_cw = 0; e_ccw = 0; e_click = 0; e_long = 0;
  endtask

  // One clock edge of the reference behaviour, using the sampled inputs
  task automatic model_step();
    int idx, cur, d, amt;
    m_cyc++;
    e_cw = 0; e_ccw = 0; e_click = 0; e_long = 0;
    idx = code_idx({a_in, b_in});
    if (m_wait) begin
      if (idx == 0) begin
        m_wait = 0;
        m_p = 0;
      end
    end else begin
      cur = ((m_p % 4) + 4) % 4;
      d = (idx - cur + 4) % 4;
      if (d == 1) m_p++;
      else if (d == 3) m_p--;
      else if (d == 2) m_wait = 1;
      if (m_p == 4) begin e_cw = 1; m_p = 0; end
      else if (m_p == -4) begin e_ccw = 1; m_p = 0; end
    end
    amt = 1;
`ifdef ENC_ACCEL_EN
    if (m_have_last && (m_cyc - m_last) <= ACC_CYC) amt = ACC_STEP;
`endif
    if (e_cw || e_ccw) begin
      m_have_last = 1;
      m_last = m_cyc;
      m_pos = e_cw ? m_pos + amt : m_pos - amt;
      if (m_pos > PMAX) m_pos = PMAX;
      if (m_pos < PMIN) m_pos = PMIN;
    end
    if (btn_in) begin
      if (m_press < LONG) begin
        m_press++;
        if (m_press == LONG) e_long = 1;
      end
    end else begin
      if (m_press > 0 && m_press < LONG) e_click = 1;
      m_press = 0;
    end
    if (e_long) m_pos = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("pos", pos, m_pos);
    chk("step_cw", step_cw, e_cw);
    chk("step_ccw", step_ccw, e_ccw);
    chk("btn_click", btn_click, e_click);
    chk("btn_long", btn_long, e_long);
    n_cw += int'(step_cw);
    n_ccw += int'(step_ccw);
    n_click += int'(btn_click);
    n_long += int'(btn_long);
  endtask

  task automatic clr_counts();
    n_cw = 0; n_ccw = 0; n_click = 0; n_long = 0;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {a_in, b_in} = ab;
    repeat (n) tick();
  endtask

  task automatic detent_cw(input int h);
    hold(2'b01, h); hold(2'b00, h); hold(2'b10, h); hold(2'b11, h);
  endtask

  task automatic detent_ccw(input int h);
    hold(2'b10, h); hold(2'b00, h); hold(2'b01, h); hold(2'b11, h);
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_pos"}, pos, 0);
    chk({t, "_cw"}, step_cw, 0);
    chk({t, "_ccw"}, step_ccw, 0);
    chk({t, "_click"}, btn_click, 0);
    chk({t, "_long"}, btn_long, 0);
  endtask

  // Asserts rstn between clock edges and checks the outputs clear at once
  task automatic async_reset(input string t);
    rstn = 1'b0;
    #2;
    chk_reset_vals(t);
    a_in = 1'b1; b_in = 1'b1; btn_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int long_at, r, cur, nxt, btn_left, n;
    model_reset();
    clr_counts();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rstn = 1'b1;
    hold(2'b11, 3);

    // 1: clean CW detent, each code held 4 cycles
    clr_counts();
    detent_cw(4);
    chk("t1_ncw", n_cw, 1);
    chk("t1_nccw", n_ccw, 0);
    chk("t1_pos", pos, 1);

    // 2: bounce inside a detent
    async_reset("t2_rst");
    clr_counts();
    hold(2'b11, 2); hold(2'b01, 2); hold(2'b11, 2); hold(2'b01, 2);
    hold(2'b00, 2); hold(2'b10, 2); hold(2'b11, 2);
    chk("t2_ncw", n_cw, 1);
    chk("t2_pos", pos, 1);

    // 3: illegal jump, then a clean CCW detent
    async_reset("t3_rst");
    clr_counts();
    hold(2'b11, 2); hold(2'b00, 3); hold(2'b10, 3); hold(2'b11, 3);
    chk("t3_nostep", n_cw + n_ccw, 0);
    chk("t3_pos0", pos, 0);
    detent_ccw(2);
    chk("t3_nccw", n_ccw, 1);
    chk("t3_pos", pos, -1);

    // 4: saturation both ways
    async_reset("t4_rst");
    repeat (100) detent_cw(1);
`ifndef ENC_ACCEL_EN
    chk("t4_pos100", pos, 100);
`endif
    clr_counts();
    detent_cw(1);
    chk("t4_cw_at_max", n_cw, 1);
    chk("t4_hold_max", pos, 100);
    async_reset("t4_rst2");
    repeat (100) detent_ccw(1);
    clr_counts();
    detent_ccw(1);
    chk("t4_ccw_at_min", n_ccw, 1);
    chk("t4_hold_min", pos, -100);

    // 5: short press -> click; long press -> recentre, no click
    async_reset("t5_rst");
    clr_counts();
    btn_in = 1'b1;
    repeat (200) tick();
    btn_in = 1'b0;
    repeat (3) tick();
    chk("t5_click", n_click, 1);
    chk("t5_nolong", n_long, 0);
    repeat (37) detent_cw(16);
    chk("t5_pos37", pos, 37);
    clr_counts();
    long_at = 0;
    btn_in = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      tick();
      if (btn_long && long_at == 0) long_at = i;
    end
    chk("t5_long_cycle", long_at, LONG);
    chk("t5_recentre", pos, 0);
    btn_in = 1'b0;
    repeat (3) tick();
    chk("t5_noclick", n_click, 0);
    chk("t5_nlong", n_long, 1);

    // 6: reset mid-detent and mid-press
    async_reset("t6_rst");
    hold(2'b11, 2); hold(2'b01, 2); hold(2'b00, 2);
    async_reset("t6_mid_detent");
    btn_in = 1'b1;
    repeat (600) tick();
    async_reset("t6_mid_press");
    clr_counts();
    detent_cw(4);
    chk("t6_pos", pos, 1);
    chk("t6_noclick", n_click, 0);

`ifdef ENC_ACCEL_EN
    // 7: two detents 30 cycles apart
    async_reset("t7_rst");
    detent_cw(1);
    chk("t7_pos1", pos, 1);
    hold(2'b11, 26);
    detent_cw(1);
    chk("t7_pos5", pos, 5);
`endif

    // Randomized walk over codes and button presses
    async_reset("rand_rst");
    btn_left = 0;
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      cur = code_idx({a_in, b_in});
      if (r < 40)      nxt = (cur + 1) % 4;
      else if (r < 65) nxt = (cur + 3) % 4;
      else if (r < 95) nxt = cur;
      else             nxt = (cur + 2) % 4;
      {a_in, b_in} = idx_code(nxt);
      if (btn_left == 0) begin
        if (btn_in) btn_in = 1'b0;
        else if ($urandom_range(0, 49) == 0) begin
          btn_in = 1'b1;
          btn_left = $urandom_range(1, 1400);
        end
      end
      n = $urandom_range(1, 3);
      repeat (n) begin
        tick();
        if (btn_left > 0) btn_left--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
